// File: rtl/p09_vga_pkg.sv
// Shared raster timing defaults (640x480@60) and sync polarity helpers for the video pipeline.
package p09_vga_pkg;

  localparam int unsigned DEF_H_DISPLAY = 640;
  localparam int unsigned DEF_H_FRONT   = 16;
  localparam int unsigned DEF_H_SYNC    = 96;
  localparam int unsigned DEF_H_BACK    = 48;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_FRONT   = 10;
  localparam int unsigned DEF_V_SYNC    = 2;
  localparam int unsigned DEF_V_BACK    = 33;

  localparam int unsigned H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int unsigned V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int unsigned DEF_SYNC_ACTIVE_LOW = 1;
  localparam logic        SYNC_ACTIVE_LEVEL   = 1'b0;

  // Pin level for a sync pulse given its logical state and the polarity setting.
  function automatic logic sync_level(input int unsigned active_low, input logic active);
    return active ^ (active_low != 0);
  endfunction

endpackage

// File: rtl/p09_hvsync_generator_if.sv
// Raster timing bundle: pixel enable in, positions/syncs/strobes out.
interface p09_hvsync_generator_if #(
  parameter int unsigned HPOS_W = 10,
  parameter int unsigned VPOS_W = 10
);
  logic              pix_en;
  logic [HPOS_W-1:0] hpos;
  logic [VPOS_W-1:0] vpos;
  logic              hsync;
  logic              vsync;
  logic              display_on;
  logic              line_start;
  logic              frame_start;

  modport master (
    input  pix_en,
    output hpos, vpos, hsync, vsync, display_on, line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  hpos, vpos, hsync, vsync, display_on, line_start, frame_start
  );
endinterface

// File: rtl/p09_wrap_counter.sv
// Enable-qualified counter that wraps TERMINAL->0; resets to TERMINAL so the first tick lands on 0.
module p09_wrap_counter #(
  parameter int unsigned W        = 10,
  parameter int unsigned TERMINAL = 799
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o,
  output logic [W-1:0] next_o
);

  localparam logic [W-1:0] TERM = W'(TERMINAL);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = (count_q == TERM) ? '0 : count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= TERM;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = (count_q == TERM);
  assign next_o  = count_d;

endmodule

// File: rtl/p09_hvsync_generator.sv
// Raster position / sync generator. Optional macro P09_HVSYNC_PIPE_EN delays hsync/vsync by one pixel.
module p09_hvsync_generator
  import p09_vga_pkg::*;
#(
  parameter int unsigned H_DISPLAY       = DEF_H_DISPLAY,
  parameter int unsigned H_FRONT         = DEF_H_FRONT,
  parameter int unsigned H_SYNC          = DEF_H_SYNC,
  parameter int unsigned H_BACK          = DEF_H_BACK,
  parameter int unsigned V_DISPLAY       = DEF_V_DISPLAY,
  parameter int unsigned V_FRONT         = DEF_V_FRONT,
  parameter int unsigned V_SYNC          = DEF_V_SYNC,
  parameter int unsigned V_BACK          = DEF_V_BACK,
  parameter int unsigned SYNC_ACTIVE_LOW = DEF_SYNC_ACTIVE_LOW,
  parameter int unsigned HPOS_W          = 10,
  parameter int unsigned VPOS_W          = 10
) (
  input logic                    clk,
  input logic                    reset,
  p09_hvsync_generator_if.master vid
);

  localparam int unsigned H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [HPOS_W-1:0] H_VIS  = HPOS_W'(H_DISPLAY);
  localparam logic [HPOS_W-1:0] HS_ON  = HPOS_W'(H_DISPLAY + H_FRONT);
  localparam logic [HPOS_W-1:0] HS_OFF = HPOS_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [VPOS_W-1:0] V_VIS  = VPOS_W'(V_DISPLAY);
  localparam logic [VPOS_W-1:0] VS_ON  = VPOS_W'(V_DISPLAY + V_FRONT);
  localparam logic [VPOS_W-1:0] VS_OFF = VPOS_W'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic SYNC_OFF = sync_level(SYNC_ACTIVE_LOW, 1'b0);

  logic [HPOS_W-1:0] h_cnt, h_next;
  logic [VPOS_W-1:0] v_cnt, v_next;
  logic              h_wrap, v_wrap;

  p09_wrap_counter #(.W(HPOS_W), .TERMINAL(H_TOT - 1)) u_hcnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .en_i    (vid.pix_en),
    .count_o (h_cnt),
    .wrap_o  (h_wrap),
    .next_o  (h_next)
  );

  p09_wrap_counter #(.W(VPOS_W), .TERMINAL(V_TOT - 1)) u_vcnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .en_i    (vid.pix_en & h_wrap),
    .count_o (v_cnt),
    .wrap_o  (v_wrap),
    .next_o  (v_next)
  );

  logic hsync_q, hsync_d, vsync_q, vsync_d;
  logic de_q, de_d, ls_q, ls_d, fs_q, fs_d;

  // Levels derive from next-state counts so they line up with the registered positions.
  always_comb begin
    hsync_d = sync_level(SYNC_ACTIVE_LOW, (h_next >= HS_ON) && (h_next < HS_OFF));
    vsync_d = sync_level(SYNC_ACTIVE_LOW, (v_next >= VS_ON) && (v_next < VS_OFF));
    de_d    = (h_next < H_VIS) && (v_next < V_VIS);
    ls_d    = vid.pix_en & h_wrap;
    fs_d    = vid.pix_en & h_wrap & v_wrap;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_q <= SYNC_OFF;
      vsync_q <= SYNC_OFF;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
    end
  end

`ifdef P09_HVSYNC_PIPE_EN
  logic hsync_p_q, vsync_p_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_p_q <= SYNC_OFF;
      vsync_p_q <= SYNC_OFF;
    end else if (vid.pix_en) begin
      hsync_p_q <= hsync_q;
      vsync_p_q <= vsync_q;
    end
  end

  assign vid.hsync = hsync_p_q;
  assign vid.vsync = vsync_p_q;
`else
  assign vid.hsync = hsync_q;
  assign vid.vsync = vsync_q;
`endif

  assign vid.hpos        = h_cnt;
  assign vid.vpos        = v_cnt;
  assign vid.display_on  = de_q;
  assign vid.line_start  = ls_q;
  assign vid.frame_start = fs_q;

endmodule
